// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Optional checksum stage is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

  localparam int         WORD_W        = 32;
  localparam int         DEF_ADDR_W    = 11;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-in / word-out bus of the program loader.
// rx side: a byte transfers on a rising edge where rx_valid && rx_ready; the
// source holds rx_data stable while rx_valid is high and rx_ready is low.
interface program_loader_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [31:0]       w_instruction;
  logic [ADDR_W-1:0] w_adrs;
  logic              w_enable;

  modport loader (
    input  rx_data, rx_valid,
    output rx_ready, w_instruction, w_adrs, w_enable
  );

  modport host (
    output rx_data, rx_valid,
    input  rx_ready, w_instruction, w_adrs, w_enable
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts incoming bytes MSB-first into a 32-bit word; word_done_o flags the
// cycle in which the fourth byte is being shifted in.
module loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (shift_i) begin
      word_d = {word_q[WORD_W-9:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = shift_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: SYNC, ADDR, LEN, LEN*4 data bytes [, CHK].
// The CHK byte and CHECK state exist only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = DEF_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic      clk,
  input  logic      resetn,
  program_loader_if.loader bus,
  output logic      cpu_en,
  output logic      load_busy,
  output logic      load_error,
  output state_e    dbg_state_o
);

  // Address bits above ADDR_W that the ADDR_HI byte must leave at zero.
  localparam logic [7:0]        HI_MASK  = 8'hFF << (ADDR_W - 8);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              cpu_en_q, cpu_en_d;
  logic              err_q, err_d;
  logic              rx_ready_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              hs;
  logic              asm_clear;
  logic              asm_shift;
  logic              word_done;
  logic              frame_done;
  logic [WORD_W-1:0] word;

  assign hs = bus.rx_valid && rx_ready_q;

  loader_word_assembler u_asm (
    .clk         (clk),
    .resetn      (resetn),
    .clear_i     (asm_clear),
    .shift_i     (asm_shift),
    .byte_i      (bus.rx_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cpu_en_d   = cpu_en_q;
    err_d      = err_q;
    asm_clear  = 1'b0;
    asm_shift  = 1'b0;
    frame_done = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
    if (hs && state_q != S_IDLE && state_q != S_CHECK) chk_d = chk_q ^ bus.rx_data;
`endif
    case (state_q)
      S_IDLE: begin
        if (hs && bus.rx_data == SYNC_BYTE) begin
          cpu_en_d  = 1'b0;
          err_d     = 1'b0;
          asm_clear = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_d     = 8'h00;
`endif
          state_d   = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        if (hs) begin
          if ((bus.rx_data & HI_MASK) != 8'h00) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d[ADDR_W-1:8] = bus.rx_data[ADDR_W-9:0];
            state_d            = S_ADDR_LO;
          end
        end
      end
      S_ADDR_LO: begin
        if (hs) begin
          addr_d[7:0] = bus.rx_data;
          state_d     = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          cnt_d[15:8] = bus.rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (hs) begin
          cnt_d[7:0] = bus.rx_data;
          if ({cnt_q[15:8], bus.rx_data} == 16'd0) frame_done = 1'b1;
          else                                      state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          asm_shift = 1'b1;
          if (word_done) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_ONE;
        cnt_d  = cnt_q - 16'd1;
        if (cnt_q == 16'd1) frame_done = 1'b1;
        else                state_d    = S_DATA;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (hs) begin
          if (bus.rx_data == chk_q) cpu_en_d = 1'b1;
          else                      err_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      state_d  = S_CHECK;
`else
      cpu_en_d = 1'b1;
      state_d  = S_IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= 16'd0;
      cpu_en_q   <= 1'b0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      cpu_en_q   <= cpu_en_d;
      err_q      <= err_d;
      rx_ready_q <= (state_d != S_WRITE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.w_enable      = (state_q == S_WRITE);
  assign bus.w_adrs        = addr_q;
  assign bus.w_instruction = word;
  assign cpu_en            = cpu_en_q;
  assign load_busy         = (state_q != S_IDLE);
  assign load_error        = err_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; frame shape follows PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int AW = 11;

  logic   clk;
  logic   resetn;
  logic   cpu_en;
  logic   load_busy;
  logic   load_error;
  state_e dbg_state;

  program_loader_if #(.ADDR_W(AW)) bus ();

  program_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .cpu_en      (cpu_en),
    .load_busy   (load_busy),
    .load_error  (load_error),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    words[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe pops one expected {address, word}
  always @(negedge clk) begin
    if (resetn && bus.w_enable === 1'b1) begin
      n_writes++;
      check("rx_ready_in_write", 64'(bus.rx_ready), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'({bus.w_adrs, bus.w_instruction}), 64'h0);
        n_fail++;
        $error("FAIL write_without_expectation observed=%0h expected=none",
               {bus.w_adrs, bus.w_instruction});
      end else begin
        check("write_addr_data", 64'({bus.w_adrs, bus.w_instruction}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = bus.rx_ready;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    if (!got) check("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic [15:0] a, input int len, input bit gaps, input bit bad_chk);
    logic [7:0] chk;
    logic [7:0] b;
    logic [15:0] l;
    l   = 16'(len);
    chk = 8'h00;
    send_byte(8'hA5, gaps);
    send_byte(a[15:8], gaps); chk ^= a[15:8];
    send_byte(a[7:0], gaps);  chk ^= a[7:0];
    send_byte(l[15:8], gaps); chk ^= l[15:8];
    send_byte(l[7:0], gaps);  chk ^= l[7:0];
    for (int w = 0; w < len; w++) begin
      exp_q.push_back({a[AW-1:0] + AW'(w), words[w]});
      for (int k = 3; k >= 0; k--) begin
        b = words[w][8*k +: 8];
        send_byte(b, gaps);
        chk ^= b;
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? 8'h00 : chk, gaps);
`else
    if (bad_chk) check("bad_chk_unsupported", 64'd0, 64'd1);
    if (len > 0) begin
      @(posedge clk); #1;
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int wr0;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    resetn       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_outputs", 64'({bus.w_enable, cpu_en, load_busy, load_error}), 64'd0);
    check("rst_bus", 64'({bus.w_adrs, bus.w_instruction}), 64'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_rx_ready", 64'(bus.rx_ready), 64'd1);
    check("idle_busy", 64'(load_busy), 64'd0);

    // single word at address 1
    wr0 = n_writes;
    words[0] = 32'hE000180F;
    send_frame(16'h0001, 1, 1'b0, 1'b0);
    check("f1_cpu_en", 64'(cpu_en), 64'd1);
    check("f1_error", 64'(load_error), 64'd0);
    check("f1_busy", 64'(load_busy), 64'd0);
    check("f1_writes", 64'(n_writes - wr0), 64'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // same frame with a bad checksum: write happens, CPU stays off
    wr0 = n_writes;
    send_frame(16'h0001, 1, 1'b0, 1'b1);
    check("badchk_cpu_en", 64'(cpu_en), 64'd0);
    check("badchk_error", 64'(load_error), 64'd1);
    check("badchk_writes", 64'(n_writes - wr0), 64'd1);
`endif

    // address wrap 2047 -> 0
    wr0 = n_writes;
    words[0] = 32'hFFFF0000;
    words[1] = 32'hAAAAAAAA;
    send_frame(16'h07FF, 2, 1'b0, 1'b0);
    check("wrap_cpu_en", 64'(cpu_en), 64'd1);
    check("wrap_error", 64'(load_error), 64'd0);
    check("wrap_writes", 64'(n_writes - wr0), 64'd2);

    // garbage in IDLE, then an out-of-range ADDR_HI
    wr0 = n_writes;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    check("garbage_busy", 64'(load_busy), 64'd0);
    check("garbage_cpu_en", 64'(cpu_en), 64'd1);
    send_byte(8'hA5, 1'b0);
    check("sync_cpu_en_falls", 64'(cpu_en), 64'd0);
    check("sync_busy", 64'(load_busy), 64'd1);
    send_byte(8'h08, 1'b0);
    check("addrhi_error", 64'(load_error), 64'd1);
    check("addrhi_idle", 64'(load_busy), 64'd0);
    check("addrhi_cpu_en", 64'(cpu_en), 64'd0);
    check("addrhi_writes", 64'(n_writes - wr0), 64'd0);

    // LEN=0 run-only frame
    wr0 = n_writes;
    send_frame(16'h0010, 0, 1'b0, 1'b0);
    check("len0_cpu_en", 64'(cpu_en), 64'd1);
    check("len0_error", 64'(load_error), 64'd0);
    check("len0_writes", 64'(n_writes - wr0), 64'd0);

    // 3 words with random rx_valid gaps
    wr0 = n_writes;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    send_frame(16'h0123, 3, 1'b1, 1'b0);
    check("gaps_cpu_en", 64'(cpu_en), 64'd1);
    check("gaps_writes", 64'(n_writes - wr0), 64'd3);

    // reset after the 2nd data byte
    wr0 = n_writes;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    resetn = 1'b0;
    #1;
    check("midrst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("midrst_outputs", 64'({bus.w_enable, cpu_en, load_busy, load_error}), 64'd0);
    check("midrst_bus", 64'({bus.w_adrs, bus.w_instruction}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_writes", 64'(n_writes - wr0), 64'd0);
    words[0] = 32'h12345678;
    send_frame(16'h0005, 1, 1'b0, 1'b0);
    check("post_rst_cpu_en", 64'(cpu_en), 64'd1);
    check("post_rst_writes", 64'(n_writes - wr0), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
